vend_change_dispenser: RTL and testbench

Output side of the vending controller. Takes the accumulated credit, in 5-cent units, when a vend or refund is requested. Drives a product-release handshake, then pays the change out one coin at a time over a req/ack handshake to the coin hopper. Coin codes use the same 2-bit encoding as the coin-input encoder (00 none, 01 nickel, 10 dime, 11 quarter).

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_change_dispenser_change_select.sv | 26 ++
 rtl/vend_change_dispenser.sv | 167 ++++++++++++++++
 tb/tb_vend_change_dispenser.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin encoding, coin values and dispenser state encoding for the vending controller.
// FAULT state exists only when HOPPER_TIMEOUT_EN is defined.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    NICKEL    = 2'b01,
    DIME      = 2'b10,
    QUARTER   = 2'b11
  } coin_e;

  localparam logic [3:0] NICKEL_U  = 4'd1;
  localparam logic [3:0] DIME_U    = 4'd2;
  localparam logic [3:0] QUARTER_U = 4'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VEND  = 3'd1,
    SEL   = 3'd2,
    COIN  = 3'd3,
    DONE  = 3'd4
`ifdef HOPPER_TIMEOUT_EN
    ,
    FAULT = 3'd5
`endif
  } state_e;

endpackage

// File: rtl/vend_change_dispenser_change_select.sv
// Combinational greedy coin picker: largest coin not exceeding the remaining change.
// remain=0 yields COIN_NONE with value 0.
module change_select
  import vend_pkg::*;
(
  input  logic [3:0] remain,
  output coin_e      coin,
  output logic [3:0] value
);

  always_comb begin
    coin  = COIN_NONE;
    value = 4'd0;
    if (remain >= QUARTER_U) begin
      coin  = QUARTER;
      value = QUARTER_U;
    end else if (remain >= DIME_U) begin
      coin  = DIME;
      value = DIME_U;
    end else if (remain != 4'd0) begin
      coin  = NICKEL;
      value = NICKEL_U;
    end
  end

endmodule

// File: rtl/vend_change_dispenser.sv
// Vending output side: product release handshake, then coin-by-coin change payout to the hopper.
// Define HOPPER_TIMEOUT_EN to add a hopper ack timeout that parks the FSM in FAULT until reset.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS    = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       refund,
  input  logic [3:0] credit,
  output logic       busy,
  output logic       product_req,
  input  logic       product_ack,
  output logic       coin_req,
  output logic [1:0] coin_code,
  input  logic       coin_ack,
  output logic       done,
  output logic [3:0] change_total,
  output logic       short_credit,
  output logic       fault
);

  localparam logic [3:0] PRICE = 4'(PRICE_UNITS);

  if (PRICE_UNITS < 1 || PRICE_UNITS > 15) begin : g_bad_price
    $error("PRICE_UNITS must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Handshakes: product_req and coin_req are held high until the matching ack is sampled
  // high on a rising edge; acks outside VEND/COIN are ignored.
  state_e     state, state_next;
  logic [3:0] remain;
  logic [3:0] acc;
  logic [3:0] coin_val;
  coin_e      coin_reg;
  coin_e      sel_coin;
  logic [3:0] sel_val;

  change_select u_change_select (
    .remain (remain),
    .coin   (sel_coin),
    .value  (sel_val)
  );

`ifdef HOPPER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == COIN) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    busy        = (state != IDLE);
    product_req = 1'b0;
    coin_req    = 1'b0;
    done        = 1'b0;
    fault       = 1'b0;
    case (state)
      IDLE: begin
        if (refund) begin
          state_next = SEL;
        end else if (start) begin
          state_next = (credit >= PRICE) ? VEND : SEL;
        end
      end
      VEND: begin
        product_req = 1'b1;
        if (product_ack) state_next = SEL;
      end
      SEL: begin
        state_next = (remain == 4'd0) ? DONE : COIN;
      end
      COIN: begin
        coin_req = 1'b1;
        if (coin_ack) begin
          state_next = SEL;
`ifdef HOPPER_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_next = FAULT;
`endif
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
`ifdef HOPPER_TIMEOUT_EN
      FAULT: begin
        fault = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: the coin picked in SEL is frozen in coin_reg/coin_val for the whole COIN wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      remain       <= 4'd0;
      acc          <= 4'd0;
      coin_val     <= 4'd0;
      coin_reg     <= COIN_NONE;
      change_total <= 4'd0;
      short_credit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (refund) begin
            remain <= credit;
          end else if (start) begin
            if (credit >= PRICE) begin
              remain       <= credit - PRICE;
              short_credit <= 1'b0;
            end else begin
              remain       <= credit;
              short_credit <= 1'b1;
            end
          end
        end
        SEL: begin
          coin_reg <= sel_coin;
          coin_val <= sel_val;
        end
        COIN: begin
          if (coin_ack) begin
            remain <= remain - coin_val;
            acc    <= acc + coin_val;
          end
        end
        DONE: begin
          change_total <= acc;
          acc          <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  assign coin_code = coin_reg;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Self-checking bench for vend_change_dispenser: table of transactions with a coin scoreboard,
// plus hand-written reset-abort and (with HOPPER_TIMEOUT_EN) hopper-timeout sequences.
module tb_vend_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, refund, product_ack, coin_ack;
  logic [3:0] credit;
  logic       busy, product_req, coin_req, done, short_credit, fault;
  logic [1:0] coin_code;
  logic [3:0] change_total;

  int checks = 0;
  int passed = 0;
  logic [1:0] exp_q[$];

`ifdef HOPPER_TIMEOUT_EN
  localparam int TMO = 4;
  localparam int LONG_DLY = 3;
`else
  localparam int TMO = 255;
  localparam int LONG_DLY = 5;
`endif

  vend_change_dispenser #(.PRICE_UNITS(7), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .refund       (refund),
    .credit       (credit),
    .busy         (busy),
    .product_req  (product_req),
    .product_ack  (product_ack),
    .coin_req     (coin_req),
    .coin_code    (coin_code),
    .coin_ack     (coin_ack),
    .done         (done),
    .change_total (change_total),
    .short_credit (short_credit),
    .fault        (fault)
  );

  // Clock/reset: 10 ns period; inputs driven and outputs sampled on the falling edge.
  always #5 clk = ~clk;

  typedef struct {
    bit             s;
    bit             r;
    logic [3:0]     cr;
    int             dly;
    bit             prod;
    int             ncoins;
    logic [3:0][1:0] coins;
    logic [3:0]     total;
    bit             short_c;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(bit s, bit r, logic [3:0] cr, int dly, bit prod, int n,
                              logic [1:0] c0, logic [1:0] c1, logic [1:0] c2, logic [1:0] c3,
                              logic [3:0] total, bit short_c);
    vec_t v;
    v.s = s; v.r = r; v.cr = cr; v.dly = dly; v.prod = prod; v.ncoins = n;
    v.coins[0] = c0; v.coins[1] = c1; v.coins[2] = c2; v.coins[3] = c3;
    v.total = total; v.short_c = short_c;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic run_txn(input vec_t v);
    int cyc;
    int dly;
    bit fin;
    @(negedge clk);
    start = v.s; refund = v.r; credit = v.cr;
    for (int i = 0; i < v.ncoins; i++) exp_q.push_back(v.coins[i]);
    @(negedge clk);
    start = 1'b0; refund = 1'b0; credit = 4'($urandom_range(0, 15));
    chk("busy_after_request", busy, 1);
    chk("product_req_latency", product_req, v.prod);
    if (v.prod) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("product_req_held", product_req, 1);
      end
      product_ack = 1'b1;
      @(negedge clk);
      product_ack = 1'b0;
      chk("product_req_drop", product_req, 0);
    end
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 100) begin
      cyc++;
      chk("no_stray_product_req", product_req, 0);
      if (coin_req) begin
        chk("coin_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("coin_code", coin_code, exp_q.pop_front());
        chk("fault_idle", fault, 0);
        dly = (v.dly < 0) ? $urandom_range(0, 2) : v.dly;
        for (int k = 0; k < dly; k++) begin
          start = 1'b1; refund = 1'b1;
          @(negedge clk);
          chk("coin_req_held", coin_req, 1);
          chk("coin_code_stable", coin_code, v.coins[v.ncoins - 1 - exp_q.size()]);
        end
        start = 1'b0; refund = 1'b0;
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        chk("coin_req_gap", coin_req, 0);
      end else if (done) begin
        chk("all_coins_paid", exp_q.size(), 0);
        exp_q.delete();
        fin = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_not_busy", busy, 0);
        chk("change_total", change_total, v.total);
        chk("short_credit", short_credit, v.short_c);
      end else begin
        @(negedge clk);
      end
    end
    chk("txn_completed", fin, 1);
  endtask

  task automatic wait_coin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = coin_req;
    end
  endtask

  initial begin
    bit ok;
    int done_seen;
    reset = 1'b1; start = 1'b0; refund = 1'b0; credit = 4'd0;
    product_ack = 1'b0; coin_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_product_req", product_req, 0);
    chk("rst_coin_req", coin_req, 0);
    chk("rst_coin_code", coin_code, 0);
    chk("rst_done", done, 0);
    chk("rst_change_total", change_total, 0);
    chk("rst_short_credit", short_credit, 0);
    chk("rst_fault", fault, 0);
    reset = 1'b0;

    vecs[0]  = mk(1, 0, 15, 0,        1, 3, 2'b11, 2'b10, 2'b01, 2'b00,  8, 0);
    vecs[1]  = mk(1, 0,  7, 0,        1, 0, 2'b00, 2'b00, 2'b00, 2'b00,  0, 0);
    vecs[2]  = mk(0, 1,  4, -1,       0, 2, 2'b10, 2'b10, 2'b00, 2'b00,  4, 0);
    vecs[3]  = mk(1, 1,  9, 0,        0, 3, 2'b11, 2'b10, 2'b10, 2'b00,  9, 0);
    vecs[4]  = mk(1, 0,  3, -1,       0, 2, 2'b10, 2'b01, 2'b00, 2'b00,  3, 1);
    vecs[5]  = mk(0, 1,  0, 0,        0, 0, 2'b00, 2'b00, 2'b00, 2'b00,  0, 1);
    vecs[6]  = mk(1, 0, 15, LONG_DLY, 1, 3, 2'b11, 2'b10, 2'b01, 2'b00,  8, 0);
    vecs[7]  = mk(0, 1, 14, -1,       0, 4, 2'b11, 2'b11, 2'b10, 2'b10, 14, 0);
    vecs[8]  = mk(1, 0,  6, 0,        0, 2, 2'b11, 2'b01, 2'b00, 2'b00,  6, 1);
    vecs[9]  = mk(1, 0, 12, 2,        1, 1, 2'b11, 2'b00, 2'b00, 2'b00,  5, 0);
    vecs[10] = mk(1, 0,  8, 0,        1, 1, 2'b01, 2'b00, 2'b00, 2'b00,  1, 0);
    vecs[11] = mk(0, 1,  1, 0,        0, 1, 2'b01, 2'b00, 2'b00, 2'b00,  1, 0);
    vecs[12] = mk(0, 1,  5, 1,        0, 1, 2'b11, 2'b00, 2'b00, 2'b00,  5, 0);

    for (int i = 0; i < 12; i++) run_txn(vecs[i]);

    // Reset during the second coin of a credit-15 vend abandons the change.
    @(negedge clk);
    start = 1'b1; credit = 4'd15;
    @(negedge clk);
    start = 1'b0;
    product_ack = 1'b1;
    @(negedge clk);
    product_ack = 1'b0;
    wait_coin(ok);
    chk("abort_first_coin_seen", ok, 1);
    chk("abort_first_coin_code", coin_code, 3);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    wait_coin(ok);
    chk("abort_second_coin_seen", ok, 1);
    chk("abort_second_coin_code", coin_code, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_coin_req", coin_req, 0);
    chk("abort_coin_code", coin_code, 0);
    chk("abort_product_req", product_req, 0);
    chk("abort_change_total", change_total, 0);
    chk("abort_short_credit", short_credit, 0);
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      done_seen += int'(done) + int'(busy);
    end
    chk("abort_no_done_or_busy", done_seen, 0);
    run_txn(vecs[12]);

`ifdef HOPPER_TIMEOUT_EN
    // Hopper never acknowledges: FAULT after TMO cycles in COIN, sticky until reset.
    @(negedge clk);
    refund = 1'b1; credit = 4'd5;
    @(negedge clk);
    refund = 1'b0;
    @(negedge clk);
    chk("tmo_coin_req_on", coin_req, 1);
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      chk("tmo_no_fault_yet", fault, 0);
      chk("tmo_coin_req_held", coin_req, 1);
    end
    @(negedge clk);
    chk("tmo_fault", fault, 1);
    chk("tmo_coin_req_drop", coin_req, 0);
    chk("tmo_busy", busy, 1);
    start = 1'b1; refund = 1'b1; credit = 4'd15;
    repeat (3) @(negedge clk);
    start = 1'b0; refund = 1'b0;
    chk("tmo_fault_sticky", fault, 1);
    chk("tmo_start_ignored", product_req, 0);
    chk("tmo_busy_sticky", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("tmo_reset_clears_fault", fault, 0);
    chk("tmo_reset_idle", busy, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
